// File: rtl/pgcd_sched_pkg.sv
// Shared types and helpers for the pgcd_sched GCD scheduler.
package pgcd_pkg;

  localparam int unsigned PGCD_W = 8;
  localparam int unsigned RR_MAX = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Round-robin pick: first valid bit searching last+1, last+2, ... modulo nreq.
  // Scanning from the farthest candidate down lets the nearest one win.
  function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] valid,
                                          input int unsigned        last,
                                          input int unsigned        nreq);
    int unsigned idx;
    int unsigned pick;
    pick = last;
    for (int unsigned k = RR_MAX; k > 0; k--) begin
      idx = last + k;
      if (idx >= nreq) idx = idx - nreq;
      if ((k <= nreq) && valid[idx[2:0]]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/pgcd_sched_if.sv
// Request/response bus between the clients and pgcd_sched.
// Optional rsp_cycles field exists only when PGCD_SCHED_CYCLES_EN is defined.
interface pgcd_sched_if
  import pgcd_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = PGCD_W,
  parameter int unsigned IDW  = $clog2(NREQ)
) ();

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_pgcd;
  logic              busy;
`ifdef PGCD_SCHED_CYCLES_EN
  logic [W:0]        rsp_cycles;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_pgcd, busy, rsp_cycles
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_pgcd, busy, rsp_cycles
  );
`else
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_pgcd, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_pgcd, busy
  );
`endif

endinterface

// File: rtl/pgcd_sched_core.sv
// Subtractive GCD engine: load max/min, then iterate until max == min.
// Datapath registers carry no reset; the scheduler always loads before use.
module pgcd_core #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] result
);

  logic [W-1:0] max_q, max_d;
  logic [W-1:0] min_q, min_d;
  logic [W-1:0] diff_c;

  // Next max/min: ordered load, or one subtract-and-reorder step.
  always_comb begin
    diff_c = max_q - min_q;
    max_d  = max_q;
    min_d  = min_q;
    if (load) begin
      max_d = (a > b) ? a : b;
      min_d = (a > b) ? b : a;
    end else begin
      max_d = (diff_c > min_q) ? diff_c : min_q;
      min_d = (diff_c > min_q) ? min_q : diff_c;
    end
  end

  // Engine registers.
  always_ff @(posedge clk) begin
    max_q <= max_d;
    min_q <= min_d;
  end

  assign done   = (max_q == min_q);
  assign result = max_q;

endmodule

// File: rtl/pgcd_sched.sv
// pgcd_sched: round-robin scheduler sharing one GCD engine between NREQ clients.
// Optional: define PGCD_SCHED_CYCLES_EN to add the rsp_cycles RUN-cycle counter.
module pgcd_sched
  import pgcd_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = PGCD_W,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic          clk,
  input  logic          rst,
  pgcd_sched_if.slave   bus
);

  state_t         state_q, state_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   res_q, res_d;
`ifdef PGCD_SCHED_CYCLES_EN
  logic [W:0]     cyc_q, cyc_d;
`endif

  logic [IDW-1:0]  grant_c;
  logic [W-1:0]    a_sel_c, b_sel_c;
  logic            req_any_c;
  logic            bypass_c;
  logic [NREQ-1:0] req_ready_c;
  logic            core_load_c;
  logic            core_done;
  logic [W-1:0]    core_result;

  // Arbitration and operand selection for the current grant candidate.
  assign req_any_c = |bus.req_valid;
  assign grant_c   = IDW'(rr_pick(RR_MAX'(bus.req_valid), 32'(last_q), NREQ));
  assign a_sel_c   = bus.req_a[int'(grant_c)*W +: W];
  assign b_sel_c   = bus.req_b[int'(grant_c)*W +: W];
  assign bypass_c  = (a_sel_c == '0) || (b_sel_c == '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_any_c) state_d = bypass_c ? DONE : LOAD;
      LOAD: state_d = RUN;
      RUN:  if (core_done) state_d = DONE;
      DONE: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    req_ready_c = '0;
    if ((state_q == IDLE) && req_any_c) req_ready_c[grant_c] = 1'b1;
    core_load_c = (state_q == LOAD);
  end

  // Job context next values: latch on accept, capture result when the engine converges.
  always_comb begin
    last_d = last_q;
    id_d   = id_q;
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
`ifdef PGCD_SCHED_CYCLES_EN
    cyc_d  = cyc_q;
`endif
    if ((state_q == IDLE) && req_any_c) begin
      last_d = grant_c;
      id_d   = grant_c;
      a_d    = a_sel_c;
      b_d    = b_sel_c;
      if (bypass_c) res_d = a_sel_c | b_sel_c;
`ifdef PGCD_SCHED_CYCLES_EN
      cyc_d  = '0;
`endif
    end
    if (state_q == RUN) begin
      if (core_done) res_d = core_result;
`ifdef PGCD_SCHED_CYCLES_EN
      if (cyc_q != '1) cyc_d = cyc_q + (W+1)'(1);
`endif
    end
  end

  // Job context registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= IDW'(NREQ-1);
      id_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
`ifdef PGCD_SCHED_CYCLES_EN
      cyc_q  <= '0;
`endif
    end else begin
      last_q <= last_d;
      id_q   <= id_d;
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
`ifdef PGCD_SCHED_CYCLES_EN
      cyc_q  <= cyc_d;
`endif
    end
  end

  pgcd_core #(.W(W)) u_core (
    .clk    (clk),
    .load   (core_load_c),
    .a      (a_q),
    .b      (b_q),
    .done   (core_done),
    .result (core_result)
  );

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_pgcd  = res_q;
`ifdef PGCD_SCHED_CYCLES_EN
  assign bus.rsp_cycles = cyc_q;
`endif

endmodule

// File: doc/pgcd_sched.md
Name: pgcd_sched

Overview:
- Shares one subtractive GCD engine between NREQ requesters.
- Round-robin arbitration picks one requester at a time. The block latches that requester's operands and sequences the engine through load and iterate.
- The result is returned on a single response channel, tagged with the requester index.
- Sits between client blocks and the GCD datapath. The datapath is instantiated inside this block as a sub-module.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 8, operand and result width in bits
- IDW, $clog2(NREQ), width of the requester ID

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_a  in  NREQ*W  operand A; requester i occupies bits [i*W +: W]
- req_b  in  NREQ*W  operand B; same packing as req_a
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  index of the requester that owns the result
- rsp_pgcd  out  W  GCD result
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, synchronous release at clk):
  - state=IDLE; req_ready=0, rsp_valid=0, rsp_id=0, rsp_pgcd=0, busy=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has top priority first.
  - Reset mid-operation aborts the job silently; no response is issued.
- Request rules:
  - A requester holds req_valid, req_a and req_b stable until it sees req_ready.
  - Transfer happens on a cycle where req_valid[i] && req_ready[i].
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any req_valid: grant g = first set bit searching last+1, last+2, ... (mod NREQ).
  - req_ready[g]=1 combinationally in this cycle.
  - At the clock edge: latch a, b, id=g; set last=g.
  - If a==0 or b==0: go to DONE with result = a|b (both zero gives 0). The engine is not used.
  - Otherwise go to LOAD.
  - req_ready is zero in every state other than IDLE.
- LOAD: drive the engine's load input for exactly one cycle with the latched a, b. Next state RUN.
- RUN:
  - Engine load=0, so the engine iterates: max,min <= max(d,min), min(d,min), where d=max-min.
  - Each cycle, sample the engine's done flag (min==max).
  - When done is set: latch result=max, go to DONE. Otherwise stay in RUN.
  - Nonzero operands always converge, in at most 2^W-1 iterations.
- DONE:
  - rsp_valid=1; rsp_id and rsp_pgcd are stable for as long as the response is pending.
  - On rsp_valid && rsp_ready: go to IDLE, and rsp_valid falls next cycle.
  - No new request is accepted in the cycle of the response handshake. Minimum one IDLE cycle between jobs.
- Latency, with acceptance in cycle C0:
  - Nonzero a==b: rsp_valid first high in C3.
  - Zero operand: rsp_valid first high in C1.
  - General case: rsp_valid first high in C3 + (number of RUN iterations before done).
- Arithmetic: all unsigned, W bits. d never underflows because max>=min is maintained.
- Fairness: a requester holding req_valid is served within NREQ jobs.

Optional Feature:
- Macro: PGCD_SCHED_CYCLES_EN.
- When defined:
  - Adds output port rsp_cycles (out, W+1 bits): the number of RUN cycles the job spent, saturating at all-ones.
  - Value is 0 for zero-operand bypass jobs and 1 for nonzero a==b.
  - Counter clears on entry to LOAD; value is held stable in DONE.
  - Reset value is 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package pgcd_pkg holds:
  - state enum (IDLE, LOAD, RUN, DONE) as a typedef;
  - default width constant PGCD_W=8;
  - a function rr_pick(valid vector, last index) returning the grant index.
- Sub-module pgcd_core contains:
  - the max/min registers and subtractor;
  - inputs clk, load, a, b; outputs done, result;
  - no reset on its datapath registers.
- The scheduler owns all control state.

Test Plan:
- Single request: req0 a=12, b=8 accepted in C0 -> rsp_valid in C5, rsp_id=0, rsp_pgcd=4, busy high C1..C5.
- Equal operands: req2 a=b=9 -> rsp_pgcd=9 in C3, id=2; with PGCD_SCHED_CYCLES_EN, rsp_cycles=1.
- Zero bypass: a=0, b=35 -> rsp_pgcd=35 in C1. Then a=0, b=0 -> rsp_pgcd=0; the engine load is never asserted.
- Round-robin: all four req_valid held after reset, each with distinct operands -> grant order 0, 1, 2, 3, 0; req_ready is one-hot or zero in every cycle.
- Backpressure: rsp_ready=0 for 10 cycles in DONE -> rsp_valid, rsp_id and rsp_pgcd held; no req_ready while waiting; next acceptance no earlier than the cycle after the handshake.
- Reset mid-RUN: a=255, b=1, assert rst during RUN -> outputs go to reset values immediately; no response; next request (a=6, b=4) -> rsp_pgcd=2.
